// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg : shared types and default sizes for register_file_mp     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_rd_port : one combinational read port, r0 forced to zero,    |
// | optional write bypass when REGFILE_BYPASS_EN is defined. Rev 1.0     |
// +----------------------------------------------------------------------+
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  output logic [DATA_W-1:0]             rd_data,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [(2**ADDR_W)*DATA_W-1:0] regs_flat
`ifdef REGFILE_BYPASS_EN
  ,
  input  logic                          byp_valid,
  input  logic [ADDR_W-1:0]             byp_addr,
  input  logic [DATA_W-1:0]             byp_data
`endif
);

  always_comb begin
    rd_data = '0;
    if (addr != '0) begin
      rd_data = regs_flat[int'(addr)*DATA_W +: DATA_W];
`ifdef REGFILE_BYPASS_EN
      if (byp_valid && (byp_addr == addr)) begin
        rd_data = byp_data;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | register_file_mp : multi-read-port register file with bulk-clear     |
// | engine and debug tap; bypass via REGFILE_BYPASS_EN. Rev 1.0          |
// +----------------------------------------------------------------------+
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int NUM_RD  = RF_NUM_RD,
  parameter int DBG_IDX = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [NUM_RD*ADDR_W-1:0] rs_addr,
  output logic [NUM_RD*DATA_W-1:0] rs_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     wr_drop,
  output logic [DATA_W-1:0]        debug_reg
);

  localparam int              NUM_REGS  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_last_idx = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] c_dbg_idx  = ADDR_W'(DBG_IDX);

  logic [DATA_W-1:0]          r_regs [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] w_regs_flat;
  rf_state_t                  r_state;
  rf_state_t                  w_state_nxt;
  logic [ADDR_W-1:0]          r_idx;
  logic [ADDR_W-1:0]          w_idx_nxt;
  logic                       w_clr_busy;
  logic                       w_wr_req;
  logic                       w_wr_en;
  logic                       r_wr_drop;

  assign w_wr_req = reg_write && (rd_addr != '0);
  assign w_wr_en  = w_wr_req && !w_clr_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RF_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      RF_IDLE: begin
        if (clr_req) begin
          w_state_nxt = RF_CLEAR;
          w_idx_nxt   = ADDR_W'(1);
        end
      end
      RF_CLEAR: begin
        if (r_idx == c_last_idx) begin
          w_state_nxt = RF_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + ADDR_W'(1);
        end
      end
      default: begin
        w_state_nxt = RF_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_clr_busy = (r_state == RF_CLEAR);
  end

  // The clear engine owns the array while busy; a write in the same edge as
  // clr_req still lands because the engine is IDLE at that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_clr_busy) begin
      r_regs[r_idx] <= '0;
    end else if (w_wr_en) begin
      r_regs[rd_addr] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= w_wr_req && w_clr_busy;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign w_regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
      regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_rd_port (
        .rd_data   (rs_data[gi*DATA_W +: DATA_W]),
        .addr      (rs_addr[gi*ADDR_W +: ADDR_W]),
        .regs_flat (w_regs_flat)
`ifdef REGFILE_BYPASS_EN
        ,
        .byp_valid (w_wr_en),
        .byp_addr  (rd_addr),
        .byp_data  (write_data)
`endif
      );
    end
  endgenerate

  assign clr_busy  = w_clr_busy;
  assign wr_drop   = r_wr_drop;
  assign debug_reg = r_regs[c_dbg_idx];

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_register_file_mp : directed + random bench for register_file_mp   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_register_file_mp;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [31:0] write_data;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic        clr_req;
  logic        clr_busy;
  logic        wr_drop;
  logic [31:0] debug_reg;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: array contents plus "clearing, next register to zero".
  logic [31:0] m_mem [32];
  bit          m_busy;
  int          m_pos;
  bit          m_drop;

  register_file_mp #(
    .DATA_W (32),
    .ADDR_W (5),
    .NUM_RD (2),
    .DBG_IDX(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_write (reg_write),
    .rd_addr   (rd_addr),
    .write_data(write_data),
    .rs_addr   (rs_addr),
    .rs_data   (rs_data),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .wr_drop   (wr_drop),
    .debug_reg (debug_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (reg_write && rd_addr != 5'd0 && !m_busy && a == rd_addr) return write_data;
`endif
    return m_mem[a];
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      logic [4:0] a;
      a = rs_addr[k*5 +: 5];
      check_eq($sformatf("rs%0d[r%0d]", k, a), rs_data[k*32 +: 32], exp_read(a));
    end
    check_eq("clr_busy", {31'h0, clr_busy}, {31'h0, m_busy});
    check_eq("wr_drop", {31'h0, wr_drop}, {31'h0, m_drop});
    check_eq("debug_reg", debug_reg, m_mem[3]);
  endtask

  task automatic model_edge();
    bit nd;
    nd = reg_write && rd_addr != 5'd0 && m_busy;
    if (m_busy) begin
      m_mem[m_pos] = 32'h0;
      if (m_pos == 31) begin
        m_busy = 0;
        m_pos  = 0;
      end else begin
        m_pos++;
      end
    end else begin
      if (reg_write && rd_addr != 5'd0) m_mem[rd_addr] = write_data;
      if (clr_req) begin
        m_busy = 1;
        m_pos  = 1;
      end
    end
    m_drop = nd;
  endtask

  // Called at posedge+1 with inputs already driven.
  task automatic tick();
    #3;
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_write  = 1'b0;
    rd_addr    = 5'd0;
    write_data = 32'h0;
    clr_req    = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_busy = 0;
    m_pos  = 0;
    m_drop = 0;
    #1;
    check_eq("rst clr_busy", {31'h0, clr_busy}, 32'h0);
    check_eq("rst wr_drop", {31'h0, wr_drop}, 32'h0);
    check_eq("rst debug_reg", debug_reg, 32'h0);
    for (int a = 0; a < 32; a++) begin
      rs_addr = {5'(31 - a), 5'(a)};
      #1;
      check_eq($sformatf("rst rs0[r%0d]", a), rs_data[31:0], 32'h0);
      check_eq($sformatf("rst rs1[r%0d]", 31 - a), rs_data[63:32], 32'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic fill_index();
    for (int i = 1; i < 32; i++) begin
      reg_write  = 1'b1;
      rd_addr    = 5'(i);
      write_data = 32'(i);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    int busy_cnt;
    int drop_cnt;
    reset   = 1'b1;
    rs_addr = '0;
    idle_inputs();
    @(posedge clk);
    #1;
    apply_reset();

    // Basic write, then read on port 1 and the debug tap
    reg_write = 1'b1; rd_addr = 5'd3; write_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    rs_addr = {5'd3, 5'd0};
    #2;
    check_eq("r3 port1", rs_data[63:32], 32'hDEADBEEF);
    check_eq("r3 debug", debug_reg, 32'hDEADBEEF);
    tick();

    // Write to r0 is ignored and never flags a drop
    reg_write = 1'b1; rd_addr = 5'd0; write_data = 32'h12345678;
    rs_addr = 10'd0;
    tick();
    idle_inputs();
    #2;
    check_eq("r0 port0", rs_data[31:0], 32'h0);
    check_eq("r0 wr_drop", {31'h0, wr_drop}, 32'h0);
    tick();

    // Full clear with a dropped write to r5 in the middle
    fill_index();
    rs_addr = {5'd5, 5'd1};
    clr_req = 1'b1;
    tick();
    clr_req  = 1'b0;
    busy_cnt = 0;
    drop_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      reg_write  = (c == 4);
      rd_addr    = 5'd5;
      write_data = 32'hBADC0DE5;
      #2;
      if (clr_busy) busy_cnt++;
      if (wr_drop) drop_cnt++;
      tick();
    end
    idle_inputs();
    check_eq("clear busy cycles", 32'(busy_cnt), 32'd31);
    check_eq("drop pulses", 32'(drop_cnt), 32'd1);
    for (int a = 0; a < 32; a++) begin
      rs_addr = {5'(a ^ 5'h1F), 5'(a)};
      #2;
      check_eq($sformatf("cleared r%0d", a), rs_data[31:0], 32'h0);
      tick();
    end

    // Reset while the engine sits at idx=10: everything zero, no resume
    fill_index();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    apply_reset();
    for (int c = 0; c < 3; c++) tick();

    // Same-cycle write/read of r7
    reg_write = 1'b1; rd_addr = 5'd7; write_data = 32'h11111111;
    tick();
    reg_write = 1'b1; rd_addr = 5'd7; write_data = 32'hA5A5A5A5;
    rs_addr = {5'd0, 5'd7};
    #2;
`ifdef REGFILE_BYPASS_EN
    check_eq("bypass r7", rs_data[31:0], 32'hA5A5A5A5);
`else
    check_eq("no-bypass r7", rs_data[31:0], 32'h11111111);
`endif
    tick();
    idle_inputs();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        apply_reset();
      end else begin
        reg_write  = 1'($urandom_range(0, 1));
        rd_addr    = 5'($urandom);
        write_data = $urandom;
        rs_addr    = 10'($urandom);
        clr_req    = ($urandom_range(0, 59) == 0);
        tick();
      end
    end
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
